result_reader: RTL

- Reads back the convolution result memory after the write stage signals completion, and streams every stored 32-bit pixel out over a valid/ready interface.
- Provides a raster-ordered readback path for verification and for a downstream consumer such as a UART or DMA bridge.
- Acts as the reader at the far end of the write stage's memory interface.
- Tags each word with row, column and last markers, and accumulates a running checksum.

---
 rtl/result_reader_pkg.sv | 17 +
 rtl/result_reader_if.sv | 45 ++++
 rtl/result_reader_fifo.sv | 59 +++++
 rtl/result_reader.sv | 117 +++++++++++
 4 files changed

// File: rtl/result_reader_pkg.sv
// Shared types and sizes for the result memory readback path.
// Imported by the interface, the skid FIFO and the reader top.
package result_pkg;

  localparam int IMG_W      = 32;
  localparam int IMG_H      = 32;
  localparam int NPIX       = IMG_W * IMG_H;
  localparam int FIFO_DEPTH = 2;
  localparam int RC_W       = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/result_reader_if.sv
// Memory read port plus the tagged output stream of the result reader.
// master = reader side, slave = memory/consumer side.
interface result_reader_if
  import result_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RC_W-1:0]   out_row;
  logic [RC_W-1:0]   out_col;
  logic              out_last;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_row,
    output out_col,
    output out_last
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last
  );

endinterface

// File: rtl/result_reader_fifo.sv
// Small synchronous FIFO that absorbs memory read returns.
// Simultaneous push and pop keep the occupancy unchanged.
module rd_skid_fifo
  import result_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_reader.sv
// Streams the result memory out in raster order after a start pulse,
// tagging row/col/last and accumulating a wrapping checksum.
module result_reader
  import result_pkg::*;
#(
  parameter int WIDTH  = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  result_reader_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] N_PIX =
    (ADDR_W + 1)'(WIDTH * HEIGHT);
  localparam logic [RC_W-1:0] LAST_COL = RC_W'(WIDTH - 1);
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(HEIGHT - 1);

  state_t            state;
  logic [ADDR_W:0]   issue_cnt;
  logic              inflight;
  logic [RC_W-1:0]   row;
  logic [RC_W-1:0]   col;
  logic [CNT_W-1:0]  fcount;
  logic              fempty;
  logic              pop;
  logic              issue;
  logic [CNT_W:0]    credit;

  assign pop = bus.out_valid && bus.out_ready;

  // Counting the word leaving this cycle keeps 1 word/cycle flowing
  // while never holding more than FIFO_DEPTH stored or in flight.
  assign credit = {1'b0, fcount}
                + (CNT_W + 1)'(inflight)
                - (CNT_W + 1)'(pop);

  assign issue = (state == RUN)
              && (issue_cnt < N_PIX)
              && (credit < (CNT_W + 1)'(FIFO_DEPTH));

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = issue_cnt[ADDR_W-1:0];
  assign bus.out_valid = !fempty;
  assign bus.out_row   = row;
  assign bus.out_col   = col;
  assign bus.out_last  = (row == LAST_ROW) && (col == LAST_COL);

  rd_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (inflight),
    .push_data (bus.mem_rdata),
    .pop       (pop),
    .pop_data  (bus.out_data),
    .count     (fcount),
    .empty     (fempty)
  );

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
      row       <= '0;
      col       <= '0;
    end else begin
      inflight <= issue;
      if (issue) issue_cnt <= issue_cnt + 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            checksum  <= '0;
            issue_cnt <= '0;
            row       <= '0;
            col       <= '0;
          end
        end
        RUN: begin
          if (pop) begin
            checksum <= checksum + bus.out_data;
            if (bus.out_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              row   <= '0;
              col   <= '0;
            end else if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
